// File: rtl/alu_mul_seq_if.sv
// Operand/result bundle between alu_mul_seq, its requester and the shared datapath ALU.
// The slave modport is the multiplier's view; master is the requester/ALU side.
interface alu_mul_seq_if;
  logic        start_i;
  logic [31:0] mcand_i;
  logic [31:0] mplier_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] product_o;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;

  modport slave (
    input  start_i, mcand_i, mplier_i, alu_result_i, alu_zero_i,
    output busy_o, done_o, product_o, alu_src1_o, alu_src2_o, alu_ctrl_o
  );

  modport master (
    output start_i, mcand_i, mplier_i, alu_result_i, alu_zero_i,
    input  busy_o, done_o, product_o, alu_src1_o, alu_src2_o, alu_ctrl_o
  );
endinterface

// File: rtl/alu_mul_seq.sv
// 32x32->64 shift-add multiplier borrowing the datapath ALU; done_o 33 cycles after start (35 with
// ALU_MUL_SEQ_SIGNED_EN for two's-complement fix-up); start_i is ignored unless idle, no queuing.
module alu_mul_seq #(
  parameter logic [3:0] ALU_ADD_CODE  = 4'b0010,
  parameter logic [3:0] ALU_SUB_CODE  = 4'b0110,
  parameter logic [3:0] ALU_IDLE_CODE = 4'b0000
) (
  input logic         clk_i,
  input logic         rst_i,
  alu_mul_seq_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FIX1, S_FIX2, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_mc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [5:0]  r_cnt;
  logic [63:0] r_product;
`ifdef ALU_MUL_SEQ_SIGNED_EN
  logic [31:0] r_mp;
`endif

  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [3:0]  w_ctrl;
  logic        w_busy;
  logic        w_done;
  logic        w_carry;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_src1      = '0;
    w_src2      = '0;
    w_ctrl      = ALU_IDLE_CODE;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_carry     = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_src1 = r_hi;
        w_src2 = r_lo[0] ? r_mc : '0;
        w_ctrl = ALU_ADD_CODE;
        // ALU has no carry out; recover it from the operand and result MSBs
        w_carry = (w_src1[31] & w_src2[31]) |
                  ((w_src1[31] | w_src2[31]) & ~bus.alu_result_i[31]);
        {w_hi_nxt, w_lo_nxt} = {w_carry, bus.alu_result_i, r_lo[31:1]};
        if (r_cnt == 6'd31) begin
`ifdef ALU_MUL_SEQ_SIGNED_EN
          w_state_nxt = S_FIX1;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
`ifdef ALU_MUL_SEQ_SIGNED_EN
      S_FIX1: begin
        w_busy      = 1'b1;
        w_src1      = r_hi;
        w_src2      = r_mc[31] ? r_mp : '0;
        w_ctrl      = ALU_SUB_CODE;
        w_hi_nxt    = bus.alu_result_i;
        w_state_nxt = S_FIX2;
      end
      S_FIX2: begin
        w_busy      = 1'b1;
        w_src1      = r_hi;
        w_src2      = r_mp[31] ? r_mc : '0;
        w_ctrl      = ALU_SUB_CODE;
        w_hi_nxt    = bus.alu_result_i;
        w_state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_mc      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      r_mp      <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (bus.start_i) begin
          r_mc  <= bus.mcand_i;
          r_lo  <= bus.mplier_i;
          r_hi  <= '0;
          r_cnt <= '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
          r_mp  <= bus.mplier_i;
`endif
        end
      end else begin
        r_hi <= w_hi_nxt;
        r_lo <= w_lo_nxt;
      end
      if (r_state == S_RUN) r_cnt <= r_cnt + 6'd1;
      // Captured on entry so product_o is already valid in the done_o cycle
      if (w_state_nxt == S_DONE) r_product <= {w_hi_nxt, w_lo_nxt};
    end
  end

`ifndef ALU_MUL_SEQ_SIGNED_EN
  logic w_unused_sub;
  assign w_unused_sub = ^ALU_SUB_CODE;
`endif
  logic w_unused_zero;
  assign w_unused_zero = bus.alu_zero_i;

  assign bus.busy_o     = w_busy;
  assign bus.done_o     = w_done;
  assign bus.product_o  = r_product;
  assign bus.alu_src1_o = w_src1;
  assign bus.alu_src2_o = w_src2;
  assign bus.alu_ctrl_o = w_ctrl;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: random and directed operands, a behavioural ALU, and a monitor
// that checks every ALU drive cycle and every done_o against arithmetic models.
`timescale 1ns/1ps
module tb_alu_mul_seq;
  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b0110;
  localparam logic [3:0] IDLE = 4'b0000;
`ifdef ALU_MUL_SEQ_SIGNED_EN
  localparam int LAT = 35;
`else
  localparam int LAT = 33;
`endif

  typedef struct {
    logic [31:0] mc;
    logic [31:0] mp;
    int          k;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  op_t  ops_q[$];

  alu_mul_seq_if u_if();

  alu_mul_seq dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath ALU
  always_comb begin
    case (u_if.alu_ctrl_o)
      ADD:     u_if.alu_result_i = u_if.alu_src1_o + u_if.alu_src2_o;
      SUB:     u_if.alu_result_i = u_if.alu_src1_o - u_if.alu_src2_o;
      default: u_if.alu_result_i = u_if.alu_src1_o & u_if.alu_src2_o;
    endcase
    u_if.alu_zero_i = (u_if.alu_result_i == 32'd0);
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] model_product(input op_t o);
    logic [63:0] a;
    logic [63:0] b;
`ifdef ALU_MUL_SEQ_SIGNED_EN
    a = {{32{o.mc[31]}}, o.mc};
    b = {{32{o.mp[31]}}, o.mp};
`else
    a = {32'd0, o.mc};
    b = {32'd0, o.mp};
`endif
    return a * b;
  endfunction

  // Step i < 32 adds multiplier bit i; HI then holds the partial product of the low i bits, scaled down by 2^i
  function automatic logic [67:0] model_drive(input op_t o, input int i);
    logic [63:0] mc64;
    logic [63:0] mp64;
    logic [63:0] part;
    logic [63:0] u;
    logic [31:0] corr1;
    logic [31:0] corr2;
    logic [31:0] hi_fix;
    mc64 = {32'd0, o.mc};
    mp64 = {32'd0, o.mp};
    if (i < 32) begin
      part = (mc64 * (mp64 & ((64'd1 << i) - 64'd1))) >> i;
      return {part[31:0], (o.mp[i] ? o.mc : 32'd0), ADD};
    end
    u      = mc64 * mp64;
    corr1  = o.mc[31] ? o.mp : 32'd0;
    corr2  = o.mp[31] ? o.mc : 32'd0;
    hi_fix = u[63:32] - corr1;
    if (i == 32) return {u[63:32], corr1, SUB};
    return {hi_fix, corr2, SUB};
  endfunction

  // Monitor: pops the scoreboard on done_o, checks ALU drive on every cycle
  always @(negedge clk) begin
    if (rst) begin
      ops_q.delete();
    end else begin
      if (u_if.busy_o) begin
        if (ops_q.size() == 0) check("busy_without_op", {95'd0, u_if.busy_o}, 96'd0);
        else check("alu_drive", {u_if.alu_src1_o, u_if.alu_src2_o, u_if.alu_ctrl_o},
                   model_drive(ops_q[0], cyc - ops_q[0].k));
      end else begin
        check("alu_idle", {u_if.alu_src1_o, u_if.alu_src2_o, u_if.alu_ctrl_o}, {64'd0, IDLE});
      end
      if (u_if.done_o) begin
        if (ops_q.size() == 0) begin
          check("spurious_done", {95'd0, u_if.done_o}, 96'd0);
        end else begin
          check("product", u_if.product_o, model_product(ops_q[0]));
          check("done_cycle", cyc - ops_q[0].k + 1, LAT);
          void'(ops_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [31:0] mc, input logic [31:0] mp);
    @(posedge clk); #1;
    u_if.start_i  = 1'b1;
    u_if.mcand_i  = mc;
    u_if.mplier_i = mp;
    @(posedge clk); #1;
    u_if.start_i  = 1'b0;
    u_if.mcand_i  = $urandom;
    u_if.mplier_i = $urandom;
    ops_q.push_back('{mc: mc, mp: mp, k: cyc});
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (u_if.done_o) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL done_timeout: got no done_o, expected one within 200 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    u_if.start_i  = 1'b0;
    u_if.mcand_i  = '0;
    u_if.mplier_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {95'd0, u_if.busy_o}, 96'd0);
    check("rst_done", {95'd0, u_if.done_o}, 96'd0);
    check("rst_product", u_if.product_o, 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(32'd15, 32'd3);
    wait_done();
    repeat (5) @(negedge clk);
    check("product_hold", u_if.product_o, 96'h2D);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    issue(32'h1234_5678, 32'hA);
    wait_done();
    issue(32'hFFFF_FFFD, 32'd5);
    wait_done();

    // Start during RUN must be ignored; start held through DONE is taken only once IDLE
    issue(32'h0BAD_F00D, 32'h8000_0001);
    repeat (4) @(posedge clk);
    #1;
    u_if.start_i  = 1'b1;
    u_if.mcand_i  = 32'h1111_1111;
    u_if.mplier_i = 32'h2222_2222;
    @(posedge clk); #1;
    u_if.start_i  = 1'b0;
    wait_done();
    a = $urandom;
    b = $urandom;
    u_if.start_i  = 1'b1;
    u_if.mcand_i  = a;
    u_if.mplier_i = b;
    @(posedge clk);
    @(posedge clk); #1;
    u_if.start_i  = 1'b0;
    ops_q.push_back('{mc: a, mp: b, k: cyc});
    wait_done();

    for (int n = 0; n < 12; n++) begin
      a = $urandom;
      b = $urandom;
      if (n == 3) a = 32'd0;
      if (n == 4) b = 32'd1;
      if (n == 5) a = 32'h8000_0000;
      issue(a, b);
      wait_done();
    end

    // Reset mid-operation: outputs clear next cycle and no done_o follows
    issue(32'hDEAD_BEEF, 32'hCAFE_F00D);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", {95'd0, u_if.busy_o}, 96'd0);
    check("mid_rst_product", u_if.product_o, 96'd0);
    check("mid_rst_ctrl", {92'd0, u_if.alu_ctrl_o}, {92'd0, IDLE});
    repeat (40) @(posedge clk);

    issue(32'd7, 32'd9);
    wait_done();
    repeat (3) @(posedge clk);
    check("queue_drained", ops_q.size(), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle shift-add multiplier that acts as the initiator on the ALU operand/result interface.
- It drives src1/src2/ctrl into the datapath ALU each cycle and consumes the result/zero outputs combinationally in the same cycle.
- This gives the single-cycle CPU a 32x32->64 multiply without a dedicated adder, and runs alongside the ALU's normal datapath use under a busy/arbitration signal.

Parameters:
ALU_ADD_CODE, 4'b0010, ctrl code driven for accumulate steps
ALU_SUB_CODE, 4'b0110, ctrl code driven for signed-correction steps (used only with the optional feature)
ALU_IDLE_CODE, 4'b0000, ctrl code driven when not busy (AND, no side effects)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
start_i  input  1  request; sampled only in IDLE
mcand_i  input  32  multiplicand, latched when start is accepted
mplier_i  input  32  multiplier, latched when start is accepted
busy_o  output  1  high while an operation is in flight; datapath must not use the ALU
done_o  output  1  one-cycle pulse when product_o is updated
product_o  output  64  final product; held until the next done_o
alu_src1_o  output  32  to ALU src1_i
alu_src2_o  output  32  to ALU src2_i
alu_ctrl_o  output  4  to ALU ctrl_i
alu_result_i  input  32  from ALU result_o, same cycle
alu_zero_i  input  1  from ALU zero_o; unused, tie-off permitted

Behaviour:
- Reset (rst_i=1 at an edge, from any state):
  - state=IDLE; busy_o=0, done_o=0, product_o=0.
  - alu_src1_o=0, alu_src2_o=0, alu_ctrl_o=ALU_IDLE_CODE; internal HI/LO/count/carry cleared.
  - Reset overrides start_i in the same cycle.
- Internal registers: MC (32, mcand copy), MP (32, mplier copy), HI (32), LO (32, holds the shifting multiplier), CNT (6).
- States:
  - IDLE -> RUN on start_i=1. Latch MC=mcand_i, MP=LO=mplier_i, HI=0, CNT=0.
  - RUN: one iteration per cycle, 32 cycles.
  - RUN -> DONE when CNT==31 is processed.
  - DONE -> IDLE unconditionally.
- RUN iteration (combinational drive, registered update):
  - Drive alu_src1_o=HI, alu_src2_o=(LO[0] ? MC : 0), alu_ctrl_o=ALU_ADD_CODE.
  - Carry-out is reconstructed from bit 31, since the ALU gives no carry: c = (a31&b31) | ((a31|b31) & ~r31), where a=src1, b=src2, r=alu_result_i.
  - Update {HI,LO} <= {c, alu_result_i, LO} >> 1 (65-bit right shift, drop LSB); CNT <= CNT+1.
- DONE: product_o <= {HI,LO}, done_o=1 for exactly this cycle, busy_o=0.
- busy_o=1 in RUN (and in FIX states below); 0 in IDLE and DONE.
- Outside RUN/FIX, ALU outputs = 0, 0, ALU_IDLE_CODE.
- Latency: start accepted at edge k; done_o high in cycle k+33; a new start is accepted at edge k+34 at the earliest.
- start_i while not in IDLE (including DONE): ignored, with no queuing.
- mcand_i/mplier_i changes after acceptance: no effect.
- product_o is unaffected by start or RUN; it changes only in DONE or on reset.
- Arithmetic is unsigned modulo 2^64 (the result is exact for 32x32).

Optional Feature:
Macro ALU_MUL_SEQ_SIGNED_EN.
- Defined: operands are two's complement and the RUN -> DONE path goes through FIX1 then FIX2, one cycle each, always executed for fixed latency.
  - FIX1: src1=HI, src2=(MC[31] ? MP : 0), ctrl=ALU_SUB_CODE; HI <= alu_result_i.
  - FIX2: src1=HI, src2=(MP[31] ? MC : 0), ctrl=ALU_SUB_CODE; HI <= alu_result_i.
  - done_o moves to cycle k+35.
- Undefined: unsigned only, no FIX states, latency as above.

Test Plan:
- Reset, then start with mcand=15, mplier=3 at edge 0 -> busy_o=1 for cycles 1..32; done_o pulse at cycle 33; product_o=64'h0000_0000_0000_002D.
- mcand=mplier=32'hFFFFFFFF -> product_o=64'hFFFFFFFE_00000001 (checks reconstructed carry).
- mplier=32'hA (bit pattern 1010), monitor the ALU ports -> in RUN cycles 1 and 3, alu_src2_o=0; in cycles 2 and 4, alu_src2_o=MC; alu_ctrl_o=4'b0010 throughout RUN.
- start at edge 0, then start_i=1 with other operands at cycle 5 -> ignored; product reflects the first operands; a second start at cycle 34 is accepted.
- start at edge 0 (prior product_o=X), rst_i=1 at cycle 10 -> next cycle busy_o=0, product_o=0, alu_ctrl_o=4'b0000; no done_o pulse follows.
- With ALU_MUL_SEQ_SIGNED_EN: mcand=-3 (32'hFFFFFFFD), mplier=5 -> done_o at cycle 35; product_o=64'hFFFFFFFF_FFFFFFF1; FIX1 drives ctrl 4'b0110.
